// File: rtl/apb_uart_pkg.sv
// APB UART register interface: shared constants and FSM encoding.
// Imported by the apb_uart_if register block.
package apb_uart_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_BAUD   = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_EMPTY = 1;
    localparam int STAT_TX_OVR   = 2;
    localparam int STAT_RX_UDR   = 3;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    localparam int BAUD_W         = 11;
    localparam int BAUD_RESET_DEF = 650;
    localparam int BAUD_MIN_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_CAPT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/apb_uart_if.sv
// APB3 slave exposing UART DATA/STATUS/BAUD/CTRL registers.
// Drives TX/RX FIFO strobes, baud divisor and a level interrupt.
module apb_uart_if
    import apb_uart_pkg::*;
#(
    parameter int BAUD_RESET = BAUD_RESET_DEF,
    parameter int BAUD_MIN   = BAUD_MIN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [3:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [BAUD_W-1:0] baud_final_value,
    output logic [7:0]        tx_fifo_dataIn,
    output logic              tx_fifo_writeEn,
    input  logic              tx_fifo_Full,
    output logic              rx_fifo_readEn,
    input  logic              rx_fifo_Empty,
    input  logic [7:0]        rx_fifo_dataOut,
    output logic              irq
);

    localparam logic [BAUD_W-1:0] BAUD_INIT = BAUD_W'(BAUD_RESET);
    localparam logic [BAUD_W-1:0] BAUD_LOW  = BAUD_W'(BAUD_MIN);

    state_t            state;
    logic [BAUD_W-1:0] baud;
    logic              rx_ie;
    logic              tx_ie;
    logic              tx_ovr;
    logic              rx_udr;
    logic [31:0]       status_word;
    logic              unused_pwdata;

    assign status_word      = {28'b0, rx_udr, tx_ovr, rx_fifo_Empty, tx_fifo_Full};
    assign pready           = (state == ST_RESP);
    assign baud_final_value = baud;
    assign unused_pwdata    = ^pwdata[31:BAUD_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            pslverr         <= 1'b0;
            prdata          <= '0;
            tx_fifo_writeEn <= 1'b0;
            rx_fifo_readEn  <= 1'b0;
            tx_fifo_dataIn  <= '0;
            baud            <= BAUD_INIT;
            rx_ie           <= 1'b0;
            tx_ie           <= 1'b0;
            tx_ovr          <= 1'b0;
            rx_udr          <= 1'b0;
            irq             <= 1'b0;
        end else begin
            tx_fifo_writeEn <= 1'b0;
            rx_fifo_readEn  <= 1'b0;
            irq <= (rx_ie & ~rx_fifo_Empty) | (tx_ie & ~tx_fifo_Full)
                 | tx_ovr | rx_udr;
            unique case (state)
                ST_IDLE: begin
                    if (psel && penable) begin
                        state <= ST_RESP;
                        case (paddr)
                            ADDR_DATA: begin
                                if (pwrite) begin
                                    if (tx_fifo_Full) begin
                                        tx_ovr  <= 1'b1;
                                        pslverr <= 1'b1;
                                    end else begin
                                        tx_fifo_dataIn  <= pwdata[7:0];
                                        tx_fifo_writeEn <= 1'b1;
                                    end
                                end else if (rx_fifo_Empty) begin
                                    rx_udr  <= 1'b1;
                                    pslverr <= 1'b1;
                                    prdata  <= '0;
                                end else begin
                                    rx_fifo_readEn <= 1'b1;
                                    state          <= ST_POP;
                                end
                            end
                            ADDR_STATUS: begin
                                if (pwrite) begin
                                    if (pwdata[STAT_TX_OVR]) tx_ovr <= 1'b0;
                                    if (pwdata[STAT_RX_UDR]) rx_udr <= 1'b0;
                                end else begin
                                    prdata <= status_word;
                                end
                            end
                            ADDR_BAUD: begin
                                if (!pwrite) begin
                                    prdata <= {{(32-BAUD_W){1'b0}}, baud};
                                end else if (pwdata[BAUD_W-1:0] >= BAUD_LOW) begin
                                    baud <= pwdata[BAUD_W-1:0];
                                end else begin
                                    pslverr <= 1'b1;
                                end
                            end
                            ADDR_CTRL: begin
                                if (pwrite) begin
                                    rx_ie <= pwdata[CTRL_RX_IE];
                                    tx_ie <= pwdata[CTRL_TX_IE];
                                end else begin
                                    prdata <= {30'b0, tx_ie, rx_ie};
                                end
                            end
                            default: begin
                                pslverr <= 1'b1;
                                prdata  <= '0;
                            end
                        endcase
                    end
                end
                ST_POP:  state <= ST_CAPT;
                // FIFO output is valid by the second edge after the pop.
                ST_CAPT: begin
                    prdata <= {24'b0, rx_fifo_dataOut};
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    pslverr <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_if.sv
// Self-checking bench for apb_uart_if: vector table plus
// scoreboard queue, irq, dropped-psel and reset-in-POP sequences.
module tb_apb_uart_if;
    import apb_uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [10:0] baud_final_value;
    logic [7:0]  tx_fifo_dataIn;
    logic        tx_fifo_writeEn;
    logic        tx_fifo_Full;
    logic        rx_fifo_readEn;
    logic        rx_fifo_Empty;
    logic [7:0]  rx_fifo_dataOut;
    logic        irq;

    always #5 clk = ~clk;

    apb_uart_if #(.BAUD_RESET(650), .BAUD_MIN(16)) dut (
        .clk(clk), .reset(reset),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr),
        .baud_final_value(baud_final_value),
        .tx_fifo_dataIn(tx_fifo_dataIn),
        .tx_fifo_writeEn(tx_fifo_writeEn),
        .tx_fifo_Full(tx_fifo_Full),
        .rx_fifo_readEn(rx_fifo_readEn),
        .rx_fifo_Empty(rx_fifo_Empty),
        .rx_fifo_dataOut(rx_fifo_dataOut),
        .irq(irq)
    );

    int         wcnt = 0;
    int         rcnt = 0;
    logic [7:0] last_din = 8'h00;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_dout = 8'hEE;

    assign rx_fifo_dataOut = rx_dout;

    always @(posedge clk) begin
        if (tx_fifo_writeEn) begin
            wcnt     <= wcnt + 1;
            last_din <= tx_fifo_dataIn;
        end
        if (rx_fifo_readEn) begin
            rcnt    <= rcnt + 1;
            rx_dout <= rx_byte;
        end
    end

    typedef struct {
        logic        w;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        full;
        logic        empty;
        logic [7:0]  rxb;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          wr;
        int          rd;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        logic        is_rd;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic w, input logic [3:0] a,
                                input logic [31:0] wd, input logic f,
                                input logic e, input logic [7:0] rb,
                                input logic [31:0] rd_v, input logic er,
                                input int cy, input int nw, input int nr);
        vec_t v;
        v.w = w; v.addr = a; v.wdata = wd; v.full = f; v.empty = e;
        v.rxb = rb; v.rdata = rd_v; v.err = er; v.cyc = cy;
        v.wr = nw; v.rd = nr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic xfer(input string tag, input vec_t v, input bit drop);
        exp_t e, got;
        int   cyc, w0, r0;
        e.rdata = v.rdata; e.err = v.err; e.cyc = v.cyc; e.is_rd = !v.w;
        sb.push_back(e);
        w0 = wcnt; r0 = rcnt;
        @(posedge clk); #1;
        tx_fifo_Full = v.full; rx_fifo_Empty = v.empty; rx_byte = v.rxb;
        psel = 1'b1; penable = 1'b0; pwrite = v.w;
        paddr = v.addr; pwdata = v.wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 1;
        while (!pready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (drop) begin psel = 1'b0; penable = 1'b0; end
        end
        got = sb.pop_front();
        check({tag, "_cycles"}, cyc, got.cyc);
        check({tag, "_pslverr"}, {31'b0, pslverr}, {31'b0, got.err});
        if (got.is_rd) check({tag, "_prdata"}, prdata, got.rdata);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check({tag, "_pready_low"}, {31'b0, pready}, 32'd0);
        check({tag, "_pslverr_low"}, {31'b0, pslverr}, 32'd0);
        if (got.is_rd) check({tag, "_prdata_hold"}, prdata, got.rdata);
        check({tag, "_writeEn_n"}, wcnt - w0, v.wr);
        check({tag, "_readEn_n"}, rcnt - r0, v.rd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pready"}, {31'b0, pready}, 32'd0);
        check({tag, "_pslverr"}, {31'b0, pslverr}, 32'd0);
        check({tag, "_prdata"}, prdata, 32'd0);
        check({tag, "_writeEn"}, {31'b0, tx_fifo_writeEn}, 32'd0);
        check({tag, "_readEn"}, {31'b0, rx_fifo_readEn}, 32'd0);
        check({tag, "_dataIn"}, {24'b0, tx_fifo_dataIn}, 32'd0);
        check({tag, "_baud"}, {21'b0, baud_final_value}, 32'd650);
        check({tag, "_irq"}, {31'b0, irq}, 32'd0);
    endtask

    initial begin
        int r0;
        reset = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 4'h0; pwdata = 32'h0;
        tx_fifo_Full = 1'b0; rx_fifo_Empty = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        vt.push_back(mk(0, 4'h8, 0,            0, 1, 0,     650,  0, 2, 0, 0));
        vt.push_back(mk(0, 4'h4, 0,            0, 1, 0,     2,    0, 2, 0, 0));
        vt.push_back(mk(1, 4'h0, 32'h1A5,      0, 1, 0,     0,    0, 2, 1, 0));
        vt.push_back(mk(1, 4'h0, 32'h77,       1, 1, 0,     0,    1, 2, 0, 0));
        vt.push_back(mk(0, 4'h4, 0,            1, 0, 0,     5,    0, 2, 0, 0));
        vt.push_back(mk(1, 4'h4, 32'h4,        1, 0, 0,     0,    0, 2, 0, 0));
        vt.push_back(mk(0, 4'h4, 0,            1, 0, 0,     1,    0, 2, 0, 0));
        vt.push_back(mk(0, 4'h0, 0,            0, 0, 8'h3C, 'h3C, 0, 4, 0, 1));
        vt.push_back(mk(0, 4'h0, 0,            0, 1, 0,     0,    1, 2, 0, 0));
        vt.push_back(mk(0, 4'h4, 0,            0, 1, 0,     'hA,  0, 2, 0, 0));
        vt.push_back(mk(1, 4'h4, 32'h8,        0, 1, 0,     0,    0, 2, 0, 0));
        vt.push_back(mk(0, 4'h4, 0,            0, 1, 0,     2,    0, 2, 0, 0));
        vt.push_back(mk(1, 4'h8, 32'd5,        0, 1, 0,     0,    1, 2, 0, 0));
        vt.push_back(mk(0, 4'h8, 0,            0, 1, 0,     650,  0, 2, 0, 0));
        vt.push_back(mk(1, 4'h8, 32'd16,       0, 1, 0,     0,    0, 2, 0, 0));
        vt.push_back(mk(0, 4'h8, 0,            0, 1, 0,     16,   0, 2, 0, 0));
        vt.push_back(mk(1, 4'h8, 32'd15,       0, 1, 0,     0,    1, 2, 0, 0));
        vt.push_back(mk(0, 4'h8, 0,            0, 1, 0,     16,   0, 2, 0, 0));
        vt.push_back(mk(1, 4'h8, 32'hFFFF_F945, 0, 1, 0,    0,    0, 2, 0, 0));
        vt.push_back(mk(0, 4'h8, 0,            0, 1, 0,     325,  0, 2, 0, 0));
        vt.push_back(mk(1, 4'hC, 32'hFF,       0, 1, 0,     0,    0, 2, 0, 0));
        vt.push_back(mk(0, 4'hC, 0,            0, 1, 0,     3,    0, 2, 0, 0));
        vt.push_back(mk(0, 4'h5, 0,            0, 1, 0,     0,    1, 2, 0, 0));
        vt.push_back(mk(1, 4'h1, 32'h55,       0, 1, 0,     0,    1, 2, 0, 0));
        vt.push_back(mk(1, 4'hC, 32'h0,        0, 1, 0,     0,    0, 2, 0, 0));
        vt.push_back(mk(0, 4'hC, 0,            0, 1, 0,     0,    0, 2, 0, 0));
        vt.push_back(mk(0, 4'h4, 0,            0, 1, 0,     2,    0, 2, 0, 0));

        for (int i = 0; i < vt.size(); i++)
            xfer($sformatf("v%0d", i), vt[i], 1'b0);

        check("tx_dataIn", {24'b0, last_din}, 32'hA5);
        check("baud_out", {21'b0, baud_final_value}, 32'd325);

        // rx_ie set, then Empty falls: irq follows one edge later
        xfer("ctrl_rxie", mk(1, 4'hC, 32'h1, 0, 1, 0, 0, 0, 2, 0, 0), 1'b0);
        check("irq_idle", {31'b0, irq}, 32'd0);
        rx_fifo_Empty = 1'b0;
        #1;
        check("irq_not_yet", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_rise", {31'b0, irq}, 32'd1);

        xfer("drop", mk(0, 4'h0, 0, 0, 0, 8'h5A, 'h5A, 0, 4, 0, 1), 1'b1);

        @(posedge clk); #1;
        rx_fifo_Empty = 1'b0; rx_byte = 8'h99;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("pop_readEn", {31'b0, rx_fifo_readEn}, 32'd1);
        r0 = rcnt;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_pop");
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_pop_no_readEn", rcnt - r0, 0);
        check("rst_pop_pready", {31'b0, pready}, 32'd0);
        check("rst_pop_irq", {31'b0, irq}, 32'd0);
        xfer("post_rst", mk(0, 4'h8, 0, 0, 1, 0, 650, 0, 2, 0, 0), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
